// File: rtl/load_seq_pkg.sv
// Shared types and constants for the load_c built-in self-test sequencer.
package load_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int            ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/load_seq_model.sv
// Expected-count model of the counter under test: loads the commanded value,
// counts up to all-ones and flags any disagreement with the observed count.
module load_seq_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_exp_max,
  output logic             o_mismatch
);

  logic [WIDTH-1:0] r_exp;

  assign o_exp_max  = (r_exp == {WIDTH{1'b1}});
  assign o_mismatch = (i_count != r_exp);

  // exp holds at all-ones so it never wraps while a pass is still running
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp <= '0;
    end else if (i_load) begin
      r_exp <= i_load_val;
    end else if (i_inc && !o_exp_max) begin
      r_exp <= r_exp + WIDTH'(1);
    end
  end

endmodule

// File: rtl/load_seq.sv
// Self-test sequencer for load_c: issues a series of loads, runs the counter
// to all-ones after each and counts (saturating) every cycle it disagrees.
module load_seq
  import load_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_LOADS = 3,
  parameter int STRIDE    = 3,
  parameter int START_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             load_o,
  output logic [WIDTH-1:0] load_val_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int IDX_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOADS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_load_val;
  logic [ERR_W-1:0] r_err;
  logic             w_exp_max;
  logic             w_mismatch;
  logic             w_accept_start;
  logic             w_last_pass;

  assign w_accept_start = ((r_state == IDLE) || (r_state == DONE)) && start_i;
  assign w_last_pass    = (r_idx == LAST_IDX);

  load_seq_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == LOAD),
    .i_inc      (r_state == RUN),
    .i_load_val (r_load_val),
    .i_count    (count_i),
    .o_exp_max  (w_exp_max),
    .o_mismatch (w_mismatch)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start_i) w_next_state = LOAD;
      LOAD: w_next_state = RUN;
      RUN:  if (w_exp_max) w_next_state = w_last_pass ? DONE : LOAD;
      DONE: if (start_i) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_load_val <= '0;
      r_err      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept_start) begin
        r_idx      <= '0;
        r_load_val <= WIDTH'(START_VAL);
        r_err      <= '0;
      end else if (r_state == RUN) begin
        if (w_mismatch && (r_err != ERR_MAX)) begin
          r_err <= r_err + ERR_W'(1);
        end
        // Next load value is built incrementally, wrapping mod 2**WIDTH
        if (w_exp_max && !w_last_pass) begin
          r_idx      <= r_idx + IDX_W'(1);
          r_load_val <= r_load_val + WIDTH'(STRIDE);
        end
      end
    end
  end

  assign load_o     = (r_state == LOAD);
  assign load_val_o = r_load_val;
  assign busy_o     = (r_state == LOAD) || (r_state == RUN);
  assign done_o     = (r_state == DONE);
  assign pass_o     = (r_state == DONE) && (r_err == '0);
  assign err_cnt_o  = r_err;

endmodule

// File: tb/tb_load_seq.sv
// Bench for load_seq: each instance drives a behavioural load_c model; load
// values and RUN lengths are scoreboarded against a queue of expectations.
module tb_load_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int mis_cnt = 0;
  int exp_val_q[$];
  int exp_len_q[$];

  // ---------------- instance A: defaults ----------------
  logic       a_start = 1'b0;
  logic [3:0] a_inj = 4'd0;
  logic [3:0] a_cnt;
  logic [3:0] a_count;
  logic       a_load, a_busy, a_done, a_pass;
  logic [3:0] a_val;
  logic [7:0] a_err;
  assign a_count = a_cnt + a_inj;
  always @(posedge clk) begin
    if (rst) a_cnt <= 4'd0;
    else if (a_load) a_cnt <= a_val;
    else a_cnt <= a_cnt + 4'd1;
  end
  load_seq u_a (
    .clk(clk), .reset(rst), .start_i(a_start), .count_i(a_count),
    .load_o(a_load), .load_val_o(a_val), .busy_o(a_busy),
    .done_o(a_done), .pass_o(a_pass), .err_cnt_o(a_err)
  );

  // ---------------- instance B: wrap of load value ----------------
  logic       b_start = 1'b0;
  logic [3:0] b_cnt;
  logic       b_load, b_busy, b_done, b_pass;
  logic [3:0] b_val;
  logic [7:0] b_err;
  always @(posedge clk) begin
    if (rst) b_cnt <= 4'd0;
    else if (b_load) b_cnt <= b_val;
    else b_cnt <= b_cnt + 4'd1;
  end
  load_seq #(.WIDTH(4), .NUM_LOADS(2), .STRIDE(1), .START_VAL(15)) u_b (
    .clk(clk), .reset(rst), .start_i(b_start), .count_i(b_cnt),
    .load_o(b_load), .load_val_o(b_val), .busy_o(b_busy),
    .done_o(b_done), .pass_o(b_pass), .err_cnt_o(b_err)
  );

  // ---------------- instance C: count stuck at zero ----------------
  logic       c_start = 1'b0;
  logic [3:0] c_count;
  logic       c_load, c_busy, c_done, c_pass;
  logic [3:0] c_val;
  logic [7:0] c_err;
  assign c_count = 4'd0;
  load_seq #(.WIDTH(4), .NUM_LOADS(20), .STRIDE(0), .START_VAL(0)) u_c (
    .clk(clk), .reset(rst), .start_i(c_start), .count_i(c_count),
    .load_o(c_load), .load_val_o(c_val), .busy_o(c_busy),
    .done_o(c_done), .pass_o(c_pass), .err_cnt_o(c_err)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({a_load, a_val, a_busy, a_done, a_pass, a_err} !== 16'd0) begin
      mis_cnt++;
      $display("FAIL reset_a: got outputs %h, expected 0", {a_load, a_val, a_busy, a_done, a_pass, a_err});
    end
    vec_cnt++;
    if ({b_load, b_val, b_busy, b_done, b_pass, b_err} !== 16'd0) begin
      mis_cnt++;
      $display("FAIL reset_b: got outputs %h, expected 0", {b_load, b_val, b_busy, b_done, b_pass, b_err});
    end
    vec_cnt++;
    if ({c_load, c_val, c_busy, c_done, c_pass, c_err} !== 16'd0) begin
      mis_cnt++;
      $display("FAIL reset_c: got outputs %h, expected 0", {c_load, c_val, c_busy, c_done, c_pass, c_err});
    end
    $display("reset: outputs of all instances sampled");
  endtask

  // Full default sequence on A; optional one-cycle count fault in pass 1 and
  // optional start_i pulses during RUN that must be ignored.
  task automatic test_sequence_a(input bit inject, input bit pulse_start);
    int cyc, run_len, loads, v, e;
    bit finished;
    for (int i = 0; i < 3; i++) begin
      v = (i * 3) & 15;
      exp_val_q.push_back(v);
      exp_len_q.push_back(16 - v);
    end
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    cyc = 0; run_len = 0; loads = 0; finished = 0;
    while (cyc < 200 && !finished) begin
      @(negedge clk);
      a_inj = 4'd0;
      a_start = 1'b0;
      if (a_done) begin
        finished = 1;
      end else if (a_load) begin
        if (loads > 0) begin
          e = exp_len_q.pop_front();
          vec_cnt++;
          if (run_len != e) begin
            mis_cnt++;
            $display("FAIL a_run_len: got %0d, expected %0d", run_len, e);
          end
        end
        e = exp_val_q.pop_front();
        vec_cnt++;
        if (int'(a_val) != e) begin
          mis_cnt++;
          $display("FAIL a_load_val: got %0d, expected %0d", a_val, e);
        end
        $display("A load #%0d value %0d at cycle %0d", loads, a_val, cyc);
        loads++;
        run_len = 0;
      end else if (a_busy) begin
        run_len++;
        if (inject && loads == 2 && run_len == 5) a_inj = 4'd1;
        if (pulse_start && run_len == 3) a_start = 1'b1;
      end
      if (!finished) cyc++;
    end
    vec_cnt++;
    if (!finished) begin
      mis_cnt++;
      $display("FAIL a_timeout: done_o never rose within %0d cycles", cyc);
    end
    e = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
    vec_cnt++;
    if (run_len != e) begin
      mis_cnt++;
      $display("FAIL a_last_run_len: got %0d, expected %0d", run_len, e);
    end
    vec_cnt++;
    if (cyc != 42) begin
      mis_cnt++;
      $display("FAIL a_total_cycles: got %0d, expected 42", cyc);
    end
    vec_cnt++;
    if (a_err !== (inject ? 8'd1 : 8'd0) || a_pass !== !inject || a_busy !== 1'b0) begin
      mis_cnt++;
      $display("FAIL a_result: got err=%0d pass=%0d busy=%0d, expected err=%0d pass=%0d busy=0",
               a_err, a_pass, a_busy, inject, !inject);
    end
    vec_cnt++;
    if (exp_val_q.size() != 0 || exp_len_q.size() != 0 || loads != 3) begin
      mis_cnt++;
      $display("FAIL a_scoreboard: got %0d loads, %0d values left, expected 3 loads, 0 left", loads, exp_val_q.size());
      exp_val_q.delete();
      exp_len_q.delete();
    end
    $display("A sequence inject=%0d: done at cycle %0d err=%0d pass=%0d", inject, cyc, a_err, a_pass);
  endtask

  // Restart from a failing DONE, then reset in the middle of pass 2's RUN.
  task automatic test_restart_midrun_reset();
    int loads, rl, guard;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (a_done !== 1'b0 || a_err !== 8'd0 || a_load !== 1'b1 || a_busy !== 1'b1) begin
      mis_cnt++;
      $display("FAIL a_restart: got done=%0d err=%0d load=%0d busy=%0d, expected 0 0 1 1",
               a_done, a_err, a_load, a_busy);
    end
    $display("A restart from DONE: done=%0d err=%0d", a_done, a_err);
    loads = 1; rl = 0; guard = 0;
    while (!(loads == 2 && rl == 4) && guard < 100) begin
      @(negedge clk);
      guard++;
      if (a_load) begin loads++; rl = 0; end
      else rl++;
    end
    vec_cnt++;
    if (guard >= 100) begin
      mis_cnt++;
      $display("FAIL a_reach_pass2: got %0d loads, expected 2 within 100 cycles", loads);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({a_load, a_val, a_busy, a_done, a_pass, a_err} !== 16'd0) begin
      mis_cnt++;
      $display("FAIL a_midrun_reset: got outputs %h, expected 0", {a_load, a_val, a_busy, a_done, a_pass, a_err});
    end
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (a_load !== 1'b0 || a_busy !== 1'b0) begin
      mis_cnt++;
      $display("FAIL a_idle_after_reset: got load=%0d busy=%0d, expected 0 0", a_load, a_busy);
    end
    $display("A reset mid-RUN of pass 2: outputs cleared");
  endtask

  task automatic test_wrap_b();
    int cyc, run_len, loads, e;
    bit finished;
    exp_val_q.push_back(15); exp_len_q.push_back(1);
    exp_val_q.push_back(0);  exp_len_q.push_back(16);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    cyc = 0; run_len = 0; loads = 0; finished = 0;
    while (cyc < 100 && !finished) begin
      @(negedge clk);
      if (b_done) begin
        finished = 1;
      end else if (b_load) begin
        if (loads > 0) begin
          e = exp_len_q.pop_front();
          vec_cnt++;
          if (run_len != e) begin
            mis_cnt++;
            $display("FAIL b_run_len: got %0d, expected %0d", run_len, e);
          end
        end
        e = exp_val_q.pop_front();
        vec_cnt++;
        if (int'(b_val) != e) begin
          mis_cnt++;
          $display("FAIL b_load_val: got %0d, expected %0d", b_val, e);
        end
        $display("B load #%0d value %0d at cycle %0d", loads, b_val, cyc);
        loads++;
        run_len = 0;
      end else if (b_busy) begin
        run_len++;
      end
      if (!finished) cyc++;
    end
    e = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
    vec_cnt++;
    if (!finished || run_len != e || cyc != 19) begin
      mis_cnt++;
      $display("FAIL b_timing: got done=%0d last_run=%0d cycles=%0d, expected 1 %0d 19", finished, run_len, cyc, e);
    end
    vec_cnt++;
    if (b_err !== 8'd0 || b_pass !== 1'b1 || loads != 2) begin
      mis_cnt++;
      $display("FAIL b_result: got err=%0d pass=%0d loads=%0d, expected 0 1 2", b_err, b_pass, loads);
    end
    exp_val_q.delete();
    exp_len_q.delete();
    $display("B wrap sequence: done at cycle %0d err=%0d", cyc, b_err);
  endtask

  task automatic test_saturate_c();
    int cyc, loads, prev;
    bit wrapped;
    @(posedge clk); #1 c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    cyc = 0; loads = 0; prev = 0; wrapped = 0;
    while (cyc < 1000 && !c_done) begin
      @(negedge clk);
      if (c_load) loads++;
      if (int'(c_err) < prev) wrapped = 1;
      prev = int'(c_err);
      if (!c_done) cyc++;
    end
    vec_cnt++;
    if (!c_done || cyc != 340 || loads != 20) begin
      mis_cnt++;
      $display("FAIL c_timing: got done=%0d cycles=%0d loads=%0d, expected 1 340 20", c_done, cyc, loads);
    end
    vec_cnt++;
    if (c_err !== 8'd255 || c_pass !== 1'b0 || wrapped) begin
      mis_cnt++;
      $display("FAIL c_saturate: got err=%0d pass=%0d wrapped=%0d, expected 255 0 0", c_err, c_pass, wrapped);
    end
    $display("C stuck count: done at cycle %0d err=%0d", cyc, c_err);
  endtask

  initial begin
    test_reset();
    test_sequence_a(1'b0, 1'b1);
    test_sequence_a(1'b1, 1'b0);
    test_restart_midrun_reset();
    test_sequence_a(1'b0, 1'b0);
    test_wrap_b();
    test_saturate_c();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
